// File: rtl/qpsk_frame_scheduler_pkg.sv
// Shared constants and types for the QPSK frame scheduler and its dibit mapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qpsk_pkg;

  // Constellation amplitudes: the sign of each rail is carried by these two codes
  localparam logic signed [15:0] POS = 16'sh0001;
  localparam logic signed [15:0] NEG = 16'sh8000;

  // Preamble alternates between these two dibits, starting with PRE_DIBIT_A
  localparam logic [1:0] PRE_DIBIT_A = 2'b11;
  localparam logic [1:0] PRE_DIBIT_B = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    WAIT,
    GAP
  } state_e;

endpackage

// File: rtl/qpsk_frame_scheduler_if.sv
// Byte-in / sample-out handshake bundle of the QPSK frame scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface qpsk_frame_scheduler_if;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] I_out;
  logic signed [15:0] Q_out;
  logic               out_sof;
  logic               out_eof;
  logic               underrun;

  // Environment side: feeds bytes and consumes samples
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, I_out, Q_out, out_sof, out_eof, underrun
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, I_out, Q_out, out_sof, out_eof, underrun
  );

endinterface

// File: rtl/qpsk_dibit_mapper.sv
// Maps one dibit to a QPSK (I,Q) pair: bit0 drives the I sign, bit1 the Q sign.
// Latency: 0 cycles (combinational).
// Backpressure: none; pure function of the input.
module qpsk_dibit_mapper
  import qpsk_pkg::*;
(
  input  logic [1:0]         dibit_i,
  output logic signed [15:0] i_o,
  output logic signed [15:0] q_o
);

  // A set bit selects the positive amplitude on its rail
  always_comb begin
    i_o = dibit_i[0] ? POS : NEG;
    q_o = dibit_i[1] ? POS : NEG;
  end

endmodule

// File: rtl/qpsk_frame_scheduler.sv
// Frames payload bytes as preamble + LSB-first dibit symbols + idle gap, SPS samples per symbol.
// Latency: first sample one cycle after the first byte is accepted; seamless byte-to-byte reload.
// Backpressure: samples hold while out_ready=0; bytes are only taken in IDLE/WAIT or on a byte's final sample.
module qpsk_frame_scheduler
  import qpsk_pkg::*;
#(
  parameter int SPS          = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_LEN      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  qpsk_frame_scheduler_if.slave bus
);

  localparam logic [4:0] SPS_M1 = 5'(SPS - 1);
  localparam logic [6:0] PRE_M1 = 7'(PREAMBLE_LEN - 1);
  localparam logic [6:0] GAP_M1 = 7'(GAP_LEN - 1);

  state_e     state_q, state_d;
  logic [4:0] samp_q, samp_d;     // sample index within the current symbol
  logic [6:0] sym_q, sym_d;       // preamble symbol index
  logic [6:0] gap_q, gap_d;       // idle-gap cycle count
  logic [1:0] idx_q, idx_d;       // dibit index within the captured byte
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       under_q, under_d;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               sof_c;
  logic               eof_c;
  logic [1:0]         dibit_c;
  logic               samp_last;
  logic signed [15:0] map_i, map_q;

  assign samp_last = (samp_q == SPS_M1);

  qpsk_dibit_mapper u_mapper (
    .dibit_i (dibit_c),
    .i_o     (map_i),
    .q_o     (map_q)
  );

  // Next-state and output decode for the frame sequencer
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    sym_d       = sym_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    last_d      = last_q;
    under_d     = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sof_c       = 1'b0;
    eof_c       = 1'b0;
    dibit_c     = PRE_DIBIT_A;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          byte_d  = bus.in_data;
          last_d  = bus.in_last;
          samp_d  = '0;
          sym_d   = '0;
          state_d = PREAMBLE;
        end
      end

      PREAMBLE: begin
        out_valid_c = 1'b1;
        dibit_c     = sym_q[0] ? PRE_DIBIT_B : PRE_DIBIT_A;
        sof_c       = (sym_q == '0) && (samp_q == '0);
        if (bus.out_ready) begin
          if (samp_last) begin
            samp_d = '0;
            if (sym_q == PRE_M1) begin
              sym_d   = '0;
              idx_d   = '0;
              state_d = DATA;
            end else begin
              sym_d = sym_q + 7'd1;
            end
          end else begin
            samp_d = samp_q + 5'd1;
          end
        end
      end

      DATA: begin
        out_valid_c = 1'b1;
        dibit_c     = byte_q[{idx_q, 1'b0} +: 2];
        eof_c       = (idx_q == 2'd3) && samp_last && last_q;
        if (bus.out_ready) begin
          if (samp_last) begin
            samp_d = '0;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (last_q) begin
                gap_d   = '0;
                state_d = GAP;
              end else begin
                // The next byte may only slip in on the very sample that retires this one
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                  byte_d = bus.in_data;
                  last_d = bus.in_last;
                end else begin
                  under_d = 1'b1;
                  state_d = WAIT;
                end
              end
            end
          end else begin
            samp_d = samp_q + 5'd1;
          end
        end
      end

      WAIT: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          byte_d  = bus.in_data;
          last_d  = bus.in_last;
          idx_d   = '0;
          samp_d  = '0;
          state_d = DATA;
        end
      end

      GAP: begin
        if (gap_q == GAP_M1) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 7'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Sequencer state; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      sym_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sym_q   <= sym_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      under_q <= under_d;
    end
  end

  // Samples are zeroed whenever nothing valid is on the bus
  always_comb begin
    bus.in_ready  = in_ready_c && !reset;
    bus.out_valid = out_valid_c;
    bus.I_out     = out_valid_c ? map_i : 16'sd0;
    bus.Q_out     = out_valid_c ? map_q : 16'sd0;
    bus.out_sof   = sof_c;
    bus.out_eof   = eof_c;
    bus.underrun  = under_q;
  end

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Directed bench for qpsk_frame_scheduler (SPS=4, PREAMBLE_LEN=8, GAP_LEN=4).
// Latency: n/a.
// Backpressure: exercised with a toggling out_ready.
module tb_qpsk_frame_scheduler;

  localparam logic [15:0] P = 16'h0001;
  localparam logic [15:0] N = 16'h8000;

  typedef struct packed {
    logic [7:0]       data;
    logic             toggle;
    logic [3:0][15:0] ei;
    logic [3:0][15:0] eq;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qpsk_frame_scheduler_if bus ();

  qpsk_frame_scheduler #(
    .SPS          (4),
    .PREAMBLE_LEN (8),
    .GAP_LEN      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] si[$];
  logic [15:0] sq[$];
  logic        ssof[$];
  logic        seof[$];
  int n_under, gap_cyc, inval_in_frame, accept_idx, zero_bad, stable_bad, timed_out;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic t,
                              input logic [15:0] i0, input logic [15:0] i1,
                              input logic [15:0] i2, input logic [15:0] i3,
                              input logic [15:0] q0, input logic [15:0] q1,
                              input logic [15:0] q2, input logic [15:0] q3);
    vec_t v;
    v.data = d;
    v.toggle = t;
    v.ei[0] = i0; v.ei[1] = i1; v.ei[2] = i2; v.ei[3] = i3;
    v.eq[0] = q0; v.eq[1] = q1; v.eq[2] = q2; v.eq[3] = q3;
    return v;
  endfunction

  // Drives one frame of nbytes (b0, then b1) and records every accepted sample.
  // hold_off > 0 keeps the second byte back until that many cycles after underrun.
  task automatic run_frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input logic toggle, input int hold_off);
    int  k = 0;
    int  cyc = 0;
    int  since = 0;
    bit  useen = 0;
    bit  started = 0;
    bit  eof_seen = 0;
    bit  done = 0;
    bit  allowed;
    bit  prev_stall = 0;
    logic [15:0] p_i = '0;
    logic [15:0] p_q = '0;
    logic p_sof = 1'b0;
    logic p_eof = 1'b0;
    si.delete(); sq.delete(); ssof.delete(); seof.delete();
    n_under = 0; gap_cyc = 0; inval_in_frame = 0; accept_idx = -1;
    zero_bad = 0; stable_bad = 0; timed_out = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (useen) since++;
      allowed = (k == 0) || (hold_off == 0) || (useen && since >= hold_off);
      bus.in_valid  = (k < nbytes) && allowed;
      bus.in_data   = (k == 0) ? b0 : b1;
      bus.in_last   = (k == nbytes - 1);
      bus.out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (prev_stall) begin
        if (!(bus.out_valid && bus.I_out == p_i && bus.Q_out == p_q &&
              bus.out_sof == p_sof && bus.out_eof == p_eof)) stable_bad++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      p_i = bus.I_out; p_q = bus.Q_out; p_sof = bus.out_sof; p_eof = bus.out_eof;
      if (!bus.out_valid && (bus.I_out != 0 || bus.Q_out != 0 || bus.out_sof || bus.out_eof))
        zero_bad++;
      if (bus.underrun) begin
        n_under++;
        useen = 1;
        since = 0;
      end
      if (started && !eof_seen && !bus.out_valid) inval_in_frame++;
      if (eof_seen) begin
        if (bus.in_ready) done = 1;
        else if (!bus.out_valid) gap_cyc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        si.push_back(bus.I_out);
        sq.push_back(bus.Q_out);
        ssof.push_back(bus.out_sof);
        seof.push_back(bus.out_eof);
        started = 1;
        if (bus.out_eof) eof_seen = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (k == 1) accept_idx = si.size() - 1 - 32;
        k++;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) timed_out = 1;
  endtask

  // Compares the recorded frame against preamble constants and per-byte expectations
  task automatic check_frame(input string tag, input int nbytes,
                             input logic [3:0][15:0] ei0, input logic [3:0][15:0] eq0,
                             input logic [3:0][15:0] ei1, input logic [3:0][15:0] eq1);
    int exp_n = 32 + 16 * nbytes;
    logic [15:0] e_i, e_q;
    int d, dd;
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " sample count"}, 32'(si.size()), 32'(exp_n));
    for (int n = 0; n < si.size() && n < exp_n; n++) begin
      if (n < 32) begin
        e_i = (((n / 4) % 2) == 0) ? P : N;
        e_q = e_i;
      end else begin
        d  = (n - 32) / 4;
        dd = d % 4;
        e_i = (d < 4) ? ei0[dd] : ei1[dd];
        e_q = (d < 4) ? eq0[dd] : eq1[dd];
      end
      check($sformatf("%s I[%0d]", tag, n), 32'(si[n]), 32'(e_i));
      check($sformatf("%s Q[%0d]", tag, n), 32'(sq[n]), 32'(e_q));
      check($sformatf("%s sof[%0d]", tag, n), 32'(ssof[n]), 32'(n == 0));
      check($sformatf("%s eof[%0d]", tag, n), 32'(seof[n]), 32'(n == exp_n - 1));
    end
    check({tag, " gap cycles"}, 32'(gap_cyc), 32'd4);
    check({tag, " idle zero"}, 32'(zero_bad), 32'd0);
    check({tag, " hold stable"}, 32'(stable_bad), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(8'hB4, 1'b0, N, P, P, N,  N, N, P, P);
    vecs[1] = mk(8'h1B, 1'b1, P, N, P, N,  P, P, N, N);
    vecs[2] = mk(8'hFF, 1'b0, P, P, P, P,  P, P, P, P);
    vecs[3] = mk(8'h00, 1'b1, N, N, N, N,  N, N, N, N);
    vecs[4] = mk(8'hE4, 1'b0, N, P, N, P,  N, N, P, P);

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state, including in_ready held low while reset is asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst I", 32'(bus.I_out), 32'd0);
    check("rst Q", 32'(bus.Q_out), 32'd0);
    check("rst sof", 32'(bus.out_sof), 32'd0);
    check("rst eof", 32'(bus.out_eof), 32'd0);
    check("rst underrun", 32'(bus.underrun), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("idle in_ready", 32'(bus.in_ready), 32'd1);

    // Single-byte frames, some under toggling backpressure
    for (int v = 0; v < 5; v++) begin
      run_frame(1, vecs[v].data, 8'h00, vecs[v].toggle, 0);
      check_frame($sformatf("vec%0d", v), 1, vecs[v].ei, vecs[v].eq, vecs[v].ei, vecs[v].eq);
      check($sformatf("vec%0d underrun", v), 32'(n_under), 32'd0);
    end

    // Back-to-back bytes: second byte taken on the last sample of the first, no bubble
    run_frame(2, 8'hFF, 8'h00, 1'b0, 0);
    check_frame("b2b", 2, {P, P, P, P}, {P, P, P, P}, {N, N, N, N}, {N, N, N, N});
    check("b2b accept sample", 32'(accept_idx), 32'd15);
    check("b2b bubbles", 32'(inval_in_frame), 32'd0);
    check("b2b underrun", 32'(n_under), 32'd0);

    // Underrun: second byte arrives late, WAIT shows no samples and one pulse
    run_frame(2, 8'h55, 8'hAA, 1'b0, 4);
    check_frame("urun", 2, {P, P, P, P}, {N, N, N, N}, {N, N, N, N}, {P, P, P, P});
    check("urun pulses", 32'(n_under), 32'd1);
    check("urun wait cycles", 32'(inval_in_frame), 32'd5);

    // Reset in the middle of dibit 2 of a frame
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB4;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    check("mid valid", 32'(bus.out_valid), 32'd1);
    check("mid I", 32'(bus.I_out), 32'(P));
    check("mid Q", 32'(bus.Q_out), 32'(P));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst I", 32'(bus.I_out), 32'd0);
    check("mrst Q", 32'(bus.Q_out), 32'd0);
    check("mrst eof", 32'(bus.out_eof), 32'd0);
    check("mrst in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mrst idle in_ready", 32'(bus.in_ready), 32'd1);
    run_frame(1, 8'hE4, 8'h00, 1'b0, 0);
    check_frame("post", 1, vecs[4].ei, vecs[4].eq, vecs[4].ei, vecs[4].eq);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
